// File: rtl/bosconian_pkg.sv
// Shared motion types for the ship: FSM states, WASD keycodes, 8-way dir encoding.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package bosconian_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } motion_state_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;  // W
  localparam logic [7:0] KEY_DOWN  = 8'h16;  // S
  localparam logic [7:0] KEY_LEFT  = 8'h04;  // A
  localparam logic [7:0] KEY_RIGHT = 8'h07;  // D

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_E  = 3'd2;
  localparam logic [2:0] DIR_SE = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_W  = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  // Net per-axis flags (already cancelled, so at most one per axis) to dir code.
  function automatic logic [2:0] dir_encode(input logic n, input logic s,
                                            input logic e, input logic w);
    logic [2:0] d;
    case ({n, s, e, w})
      4'b1000: d = DIR_N;
      4'b1010: d = DIR_NE;
      4'b0010: d = DIR_E;
      4'b0110: d = DIR_SE;
      4'b0100: d = DIR_S;
      4'b0101: d = DIR_SW;
      4'b0001: d = DIR_W;
      4'b1001: d = DIR_NW;
      default: d = DIR_N;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wrap_step.sv
// One axis of toroidal motion: moves pos by step in the given sign, wrapping at 0 / max.
// Latency: combinational.
// Backpressure: none.
module wrap_step #(
  parameter int POS_W = 10
) (
  input  logic [POS_W-1:0] pos,
  input  logic [3:0]       step,
  input  logic             neg,
  input  logic [POS_W-1:0] max,
  output logic [POS_W-1:0] wrapped
);

  // One extra bit so pos+step and pos+max+1 never lose their carry.
  localparam int EW = POS_W + 1;

  logic [EW-1:0] pos_e;
  logic [EW-1:0] step_e;
  logic [EW-1:0] max_e;
  logic [EW-1:0] sum;

  // Increment wraps past max back to 0; decrement below 0 wraps to the top.
  always_comb begin
    pos_e  = EW'(pos);
    step_e = EW'(step);
    max_e  = EW'(max);
    sum    = pos_e + step_e;
    if (!neg) begin
      if (sum > max_e) wrapped = POS_W'(sum - max_e - EW'(1));
      else             wrapped = POS_W'(sum);
    end else begin
      if (pos_e < step_e) wrapped = POS_W'(pos_e + max_e + EW'(1) - step_e);
      else                wrapped = POS_W'(pos_e - step_e);
    end
  end

endmodule

// File: rtl/ship_motion.sv
// Ship motion per video frame: WASD decode, accel/cruise/decel speed FSM, wrapped 8-way position.
// Latency: speed/dir register on the frame edge; position follows the registered speed one frame later.
// Backpressure: none; keycode is sampled every frame_clk edge.
module ship_motion
  import bosconian_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int POS_W        = 10,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int SPEED_MAX    = 4,
  parameter int ACCEL_FRAMES = 4,
  parameter int STICKY       = 1
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [8*NUM_KEYS-1:0] keycode,
  output logic                  moving,
  output logic [2:0]            dir,
  output logic [3:0]            speed,
  output logic [POS_W-1:0]      pos_x,
  output logic [POS_W-1:0]      pos_y
);

  localparam int              CNT_W     = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [3:0]      SPD_MAX   = 4'(SPEED_MAX);
  localparam bit              STICKY_ON = (STICKY != 0);
  localparam logic [POS_W-1:0] XM       = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM       = POS_W'(Y_MAX);

  motion_state_t    state_q, state_d;
  logic [3:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dir_q;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic [POS_W-1:0] x_next, y_next;

  logic up, down, left, right;
  logic go_n, go_s, go_e, go_w, key_valid;
  logic x_inc, x_dec, y_inc, y_dec;
  logic [3:0] step_x, step_y;

  // Collect WASD flags from every slot, then cancel opposing keys per axis.
  always_comb begin
    up    = 1'b0;
    down  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (keycode[8*k +: 8] == KEY_UP)    up    = 1'b1;
      if (keycode[8*k +: 8] == KEY_DOWN)  down  = 1'b1;
      if (keycode[8*k +: 8] == KEY_LEFT)  left  = 1'b1;
      if (keycode[8*k +: 8] == KEY_RIGHT) right = 1'b1;
    end
    go_n      = up & ~down;
    go_s      = down & ~up;
    go_e      = right & ~left;
    go_w      = left & ~right;
    key_valid = go_n | go_s | go_e | go_w;
  end

  // Speed FSM: ramp one step every ACCEL_FRAMES frames up to SPEED_MAX, and back down when released.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d = ST_ACCEL;
          speed_d = 4'd1;
          cnt_d   = '0;
        end
      end
      ST_ACCEL: begin
        if (!STICKY_ON && !key_valid) begin
          state_d = ST_DECEL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (speed_q < SPD_MAX) speed_d = speed_q + 4'd1;
          if (speed_d >= SPD_MAX) state_d = ST_CRUISE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CRUISE: begin
        if (!STICKY_ON && !key_valid) begin
          state_d = ST_DECEL;
          cnt_d   = '0;
        end
      end
      ST_DECEL: begin
        if (key_valid) begin
          state_d = ST_ACCEL;
          cnt_d   = '0;
        end else if (speed_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          speed_d = speed_q - 4'd1;
          if (speed_d == 4'd0) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        speed_d = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, speed and frame counter registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      speed_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
    end
  end

  // Axis motion comes from the registered dir/speed, so a speed change moves the ship one frame later.
  always_comb begin
    x_inc  = (dir_q == DIR_NE) || (dir_q == DIR_E) || (dir_q == DIR_SE);
    x_dec  = (dir_q == DIR_SW) || (dir_q == DIR_W) || (dir_q == DIR_NW);
    y_dec  = (dir_q == DIR_NW) || (dir_q == DIR_N) || (dir_q == DIR_NE);
    y_inc  = (dir_q == DIR_SE) || (dir_q == DIR_S) || (dir_q == DIR_SW);
    step_x = (x_inc || x_dec) ? speed_q : 4'd0;
    step_y = (y_inc || y_dec) ? speed_q : 4'd0;
  end

  wrap_step #(.POS_W(POS_W)) u_wrap_x (
    .pos     (pos_x_q),
    .step    (step_x),
    .neg     (x_dec),
    .max     (XM),
    .wrapped (x_next)
  );

  wrap_step #(.POS_W(POS_W)) u_wrap_y (
    .pos     (pos_y_q),
    .step    (step_y),
    .neg     (y_dec),
    .max     (YM),
    .wrapped (y_next)
  );

  // Heading follows any valid key in every state; position steps every frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      dir_q   <= DIR_N;
      pos_x_q <= POS_W'(X_INIT);
      pos_y_q <= POS_W'(Y_INIT);
    end else begin
      if (key_valid) dir_q <= dir_encode(go_n, go_s, go_e, go_w);
      pos_x_q <= x_next;
      pos_y_q <= y_next;
    end
  end

  assign moving = (speed_q != 4'd0);
  assign dir    = dir_q;
  assign speed  = speed_q;
  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;

endmodule

// File: tb/tb_ship_motion.sv
// Directed bench for ship_motion: expected frames are queued by the stimulus, a monitor checks them.
// Latency: checks sample on the falling edge after the frame edge they target.
// Backpressure: not applicable.
module tb_ship_motion;

  logic       clk = 1'b0;
  logic       rst [3];
  logic [15:0] key [3];
  logic       mv  [3];
  logic [2:0] dr  [3];
  logic [3:0] sp  [3];
  logic [9:0] px  [3];
  logic [9:0] py  [3];

  always #5 clk = ~clk;

  // Default parameters, sticky motion.
  ship_motion #(.STICKY(1)) u_sticky (
    .frame_clk(clk), .Reset(rst[0]), .keycode(key[0]), .moving(mv[0]),
    .dir(dr[0]), .speed(sp[0]), .pos_x(px[0]), .pos_y(py[0]));

  // Decelerating variant.
  ship_motion #(.STICKY(0)) u_slide (
    .frame_clk(clk), .Reset(rst[1]), .keycode(key[1]), .moving(mv[1]),
    .dir(dr[1]), .speed(sp[1]), .pos_x(px[1]), .pos_y(py[1]));

  // Start point chosen so full speed is reached exactly at x=638 / y=1.
  ship_motion #(.X_INIT(614), .Y_INIT(25)) u_edge (
    .frame_clk(clk), .Reset(rst[2]), .keycode(key[2]), .moving(mv[2]),
    .dir(dr[2]), .speed(sp[2]), .pos_x(px[2]), .pos_y(py[2]));

  typedef struct {
    int    cyc;
    int    id;
    int    mv;
    int    dr;
    int    sp;
    int    x;
    int    y;
    string nm;
  } exp_t;

  exp_t sb [$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // A negative expected value means "don't care" for that field.
  task automatic cmp(input string nm, input string fld, input int got, input int want);
    if (want < 0) return;
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d (edge %0d)", nm, fld, got, want, edge_cnt);
    end
  endtask

  task automatic push(input int cyc, input int id, input int m, input int d, input int s,
                      input int x, input int y, input string nm);
    exp_t e;
    e.cyc = cyc; e.id = id; e.mv = m; e.dr = d; e.sp = s; e.x = x; e.y = y; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation whose frame has arrived.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e = sb.pop_front();
      if (e.cyc < edge_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s not sampled: due edge %0d now %0d", e.nm, e.cyc, edge_cnt);
      end else begin
        cmp(e.nm, "moving", int'(mv[e.id]), e.mv);
        cmp(e.nm, "dir",    int'(dr[e.id]), e.dr);
        cmp(e.nm, "speed",  int'(sp[e.id]), e.sp);
        cmp(e.nm, "pos_x",  int'(px[e.id]), e.x);
        cmp(e.nm, "pos_y",  int'(py[e.id]), e.y);
      end
    end
  end

  // Assert reset just after a frame edge so the falling-edge check proves it acts without a clock.
  task automatic do_reset(input int id, input int xi, input int yi, input string nm);
    @(posedge clk);
    #1;
    rst[id] = 1'b1;
    key[id] = 16'h0000;
    push(edge_cnt, id, 0, 0, 0, xi, yi, nm);
    @(negedge clk);
    @(negedge clk);
    rst[id] = 1'b0;
  endtask

  initial begin : stim
    int b;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      key[i] = 16'h0000;
    end

    // Sticky ship: ramp east to cruise.
    do_reset(0, 320, 240, "rst_default");
    key[0] = 16'h0007;
    b = edge_cnt;
    push(b+1,  0, 1, 2, 1, 320, 240, "ramp_e1");
    push(b+2,  0, 1, 2, 1, 321, 240, "ramp_e2");
    push(b+4,  0, 1, 2, 1, 323, 240, "ramp_e4");
    push(b+5,  0, 1, 2, 2, 324, 240, "ramp_e5");
    push(b+8,  0, 1, 2, 2, 330, 240, "ramp_e8");
    push(b+9,  0, 1, 2, 3, 332, 240, "ramp_e9");
    push(b+12, 0, 1, 2, 3, 341, 240, "ramp_e12");
    push(b+13, 0, 1, 2, 4, 344, 240, "ramp_e13");
    push(b+20, 0, 1, 2, 4, 372, 240, "cruise_e20");
    repeat (20) @(negedge clk);

    // Reset while cruising, then opposing A+D: no valid key, stays idle.
    do_reset(0, 320, 240, "rst_cruise");
    key[0] = 16'h0704;
    b = edge_cnt;
    push(b+1, 0, 0, 0, 0, 320, 240, "ad_cancel_e1");
    push(b+3, 0, 0, 0, 0, 320, 240, "ad_cancel_e3");
    repeat (3) @(negedge clk);

    // W and D in separate slots: northeast diagonal at full step on both axes.
    key[0] = 16'h1A07;
    b = edge_cnt;
    push(b+1, 0, 1, 1, 1, 320, 240, "ne_e1");
    push(b+2, 0, 1, 1, 1, 321, 239, "ne_e2");
    push(b+5, 0, 1, 1, 2, 324, 236, "ne_e5");
    push(b+6, 0, 1, 1, 2, 326, 234, "ne_e6");
    repeat (6) @(negedge clk);

    // Non-sticky ship: reach full speed, release, decelerate to idle.
    do_reset(1, 320, 240, "rst_slide");
    key[1] = 16'h0007;
    b = edge_cnt;
    push(b+13, 1, 1, 2, 4, 344, 240, "sl_e13");
    repeat (13) @(negedge clk);
    key[1] = 16'h0000;
    b = edge_cnt;
    push(b+1,  1, 1, 2, 4, 348, 240, "dec_e1");
    push(b+4,  1, 1, 2, 4, -1, -1, "dec_e4");
    push(b+5,  1, 1, 2, 3, -1, -1, "dec_e5");
    push(b+9,  1, 1, 2, 2, -1, -1, "dec_e9");
    push(b+13, 1, 1, 2, 1, -1, -1, "dec_e13");
    push(b+16, 1, 1, 2, 1, -1, -1, "dec_e16");
    push(b+17, 1, 0, 2, 0, 388, 240, "dec_e17");
    push(b+19, 1, 0, 2, 0, 388, 240, "idle_e19");
    repeat (19) @(negedge clk);

    // Release during accel, then press A mid-decel: back to accel heading west.
    key[1] = 16'h0007;
    b = edge_cnt;
    push(b+1, 1, 1, 2, 1, -1, -1, "re_e1");
    push(b+5, 1, 1, 2, 2, -1, -1, "re_e5");
    repeat (5) @(negedge clk);
    key[1] = 16'h0000;
    b = edge_cnt;
    push(b+1, 1, 1, 2, 2, -1, -1, "acc_rel_e1");
    push(b+2, 1, 1, 2, 2, -1, -1, "acc_rel_e2");
    repeat (2) @(negedge clk);
    key[1] = 16'h0004;
    b = edge_cnt;
    push(b+1, 1, 1, 6, 2, -1, -1, "redo_e1");
    push(b+3, 1, 1, 6, 2, -1, -1, "redo_e3");
    push(b+4, 1, 1, 6, 2, -1, -1, "redo_e4");
    push(b+5, 1, 1, 6, 3, -1, -1, "redo_e5");
    repeat (5) @(negedge clk);

    // X wrap at the right edge.
    do_reset(2, 614, 25, "rst_edge_x");
    key[2] = 16'h0007;
    b = edge_cnt;
    push(b+13, 2, 1, 2, 4, 638, 25, "wrapx_e13");
    push(b+14, 2, 1, 2, 4, 2,   25, "wrapx_e14");
    push(b+15, 2, 1, 2, 4, 6,   25, "wrapx_e15");
    repeat (15) @(negedge clk);

    // Y wrap at the top edge.
    do_reset(2, 614, 25, "rst_edge_y");
    key[2] = 16'h001A;
    b = edge_cnt;
    push(b+13, 2, 1, 0, 4, 614, 1,   "wrapy_e13");
    push(b+14, 2, 1, 0, 4, 614, 477, "wrapy_e14");
    push(b+15, 2, 1, 0, 4, 614, 473, "wrapy_e15");
    repeat (15) @(negedge clk);

    // Drain with a bounded wait; anything left was never checked.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_motion.md
SHIP_MOTION -- requirements
Module: ship_motion

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2: number of simultaneous keycode slots.
REQ-002 SHALL have parameter POS_W, default 10: width of position outputs.
REQ-003 SHALL have parameter X_MAX, default 639: largest X coordinate.
REQ-004 SHALL have parameter Y_MAX, default 479: largest Y coordinate.
REQ-005 SHALL have parameters X_INIT and Y_INIT, defaults 320 and 240: position after reset.
REQ-006 SHALL have parameter SPEED_MAX, default 4, range 1..15 and at most min(X_MAX,Y_MAX): pixels per frame at full speed.
REQ-007 SHALL have parameter ACCEL_FRAMES, default 4, at least 1: frames per speed step.
REQ-008 SHALL have parameter STICKY, default 1: 1 keeps the ship moving after key release, 0 makes it decelerate to a stop.
REQ-009 SHALL have port frame_clk, input, 1 bit: the single clock, one rising edge per video frame.
REQ-010 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-011 SHALL have port keycode, input, 8*NUM_KEYS bits: slot k occupies bits [8k+7:8k]; 8'h00 means empty.
REQ-012 SHALL have port moving, output, 1 bit: high when speed is nonzero.
REQ-013 SHALL have port dir, output, 3 bits: 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
REQ-014 SHALL have port speed, output, 4 bits: current speed.
REQ-015 SHALL have ports pos_x and pos_y, outputs, POS_W bits each: ship position.

Function
REQ-016 SHALL decode key flags across all slots each edge: up=8'h1A (W), down=8'h16 (S), left=8'h04 (A), right=8'h07 (D), all other codes ignored.
REQ-017 SHALL cancel an axis when both of its opposite flags are set; a key is valid only when at least one axis is non-zero after cancellation.
REQ-018 SHALL load dir from the valid net vector on that edge, in every state; with no valid key, dir holds.
REQ-019 SHALL implement FSM IDLE, ACCEL, CRUISE, DECEL.
REQ-020 IDLE: on a valid key, SHALL go to ACCEL with speed set to 1 and the frame counter cleared on the same edge.
REQ-021 ACCEL: SHALL increment the frame counter each edge; at count ACCEL_FRAMES-1, speed increments and the counter clears; when speed reaches SPEED_MAX, SHALL go to CRUISE.
REQ-022 ACCEL with STICKY=0 and no valid key: SHALL go to DECEL with the counter cleared and speed unchanged.
REQ-023 CRUISE: with STICKY=1, SHALL remain in CRUISE; with STICKY=0 and no valid key, SHALL go to DECEL with the counter cleared.
REQ-024 DECEL: SHALL decrement speed each ACCEL_FRAMES edges; at speed 0, SHALL go to IDLE; a valid key SHALL return it to ACCEL with the counter cleared and speed kept.
REQ-025 SHALL hold speed at SPEED_MAX (no overflow) and at 0 (no underflow).
REQ-026 SHALL step position each edge by the registered speed value before that edge's update, giving one frame of latency from speed change to motion.
REQ-027 SHALL move pos_x +speed for dir 1,2,3 and −speed for dir 5,6,7; SHALL move pos_y −speed for dir 7,0,1 (N is toward smaller Y) and +speed for dir 3,4,5.
REQ-028 SHALL apply diagonals at full speed on both axes, with no normalisation.
REQ-029 SHALL wrap X: x+s > X_MAX gives x+s−X_MAX−1, and x < s on a decrement gives x+X_MAX+1−s; Y SHALL wrap identically with Y_MAX.
REQ-030 SHALL compute arithmetic at POS_W+1 bits so no intermediate value truncates.
REQ-031 SHALL drive moving as (speed != 0), combinationally from the speed register.

Reset
REQ-032 Reset high SHALL set, immediately and regardless of frame_clk: state=IDLE, speed=0, counter=0, dir=0, pos_x=X_INIT, pos_y=Y_INIT, moving=0.
REQ-033 Reset asserted mid-motion SHALL abort the motion with no partial position update; the first edge after release SHALL behave as from IDLE.

Structure
REQ-034 SHALL place the motion-state enum, the WASD keycode constants and the dir encoding in shared package bosconian_pkg.
REQ-035 SHALL use one sub-module, wrap_step, instantiated once per axis: inputs position, step magnitude, sign and max; output the wrapped position.

Verification
REQ-036 Reset with defaults -> pos=(320,240), speed=0, dir=0, moving=0.
REQ-037 Hold 8'h07 from IDLE -> speed 1 on edge 1, then 2,3,4 every 4 edges; CRUISE at edge 13; pos_x 320→321 on edge 2.
REQ-038 Slots 8'h1A and 8'h07 -> dir=1; x increments and y decrements by speed each edge.
REQ-039 pos_x=638, dir=2, speed=4 -> next pos_x=2; pos_y=1, dir=0, speed=4 -> next pos_y=477.
REQ-040 STICKY=0, release at speed 4 -> DECEL; speed 3,2,1,0 at 4-edge spacing; IDLE with moving=0; pressing 8'h04 mid-DECEL -> ACCEL with dir=6.
REQ-041 Slots 8'h04 and 8'h07 only -> no valid key, IDLE held; Reset pulsed in CRUISE -> all reset values asynchronously.
